deal_pass: RTL and testbench

// - Handles the verdict of an upstream password comparator (right/error pulses or levels).
// - Drives the door actuator (lock/unlock) and an alarm buzzer (beef).
// - MAX_ERR consecutive wrong entries force an alarm lockout of ALARM_CYCLES clocks.
// - Sits between the keypad compare logic and the board-level lock driver and buzzer.

---
 rtl/deal_pass.sv | 127 ++++++++++++
 tb/tb_deal_pass.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/deal_pass.sv
// deal_pass: password verdict handler driving the door lock and alarm buzzer.
// Define DEALPASS_BEEP_TOGGLE_EN for a square-wave buzzer during alarm.
module deal_pass #(
  parameter int MAX_ERR      = 3,
  parameter int UNLOCK_HOLD  = 8,
  parameter int ALARM_CYCLES = 16,
  parameter int BEEP_DIV     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic error,
  input  logic right,
  output logic lock,
  output logic unlock,
  output logic beef
);

  localparam int EW = $clog2(MAX_ERR + 1);
  localparam int TMAX =
    (UNLOCK_HOLD > ALARM_CYCLES) ? UNLOCK_HOLD : ALARM_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [1:0] LOCKED   = 2'd0;
  localparam logic [1:0] UNLOCKED = 2'd1;
  localparam logic [1:0] ALARM    = 2'd2;

  logic [1:0]    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [EW-1:0] err_cnt, err_cnt_n;
  logic [EW-1:0] base;
  logic          right_q, error_q;
  logic          ev_right, ev_err;

  assign ev_right = right & ~right_q;
  assign ev_err   = error & ~error_q;

  // An error while unlocked is always the first of a new run.
  assign base = (state == UNLOCKED) ? '0 : err_cnt;

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    err_cnt_n = err_cnt;
    unique case (state)
      LOCKED, UNLOCKED: begin
        if (ev_err) begin
          if (base == EW'(MAX_ERR - 1)) begin
            state_n   = ALARM;
            err_cnt_n = '0;
            timer_n   = TW'(ALARM_CYCLES);
          end else begin
            state_n   = LOCKED;
            err_cnt_n = base + EW'(1);
          end
        end else if (ev_right) begin
          state_n   = UNLOCKED;
          err_cnt_n = '0;
          timer_n   = TW'(UNLOCK_HOLD);
        end else if (state == UNLOCKED) begin
          if (timer == TW'(1)) state_n = LOCKED;
          timer_n = timer - TW'(1);
        end
      end
      ALARM: begin
        if (timer == TW'(1)) state_n = LOCKED;
        timer_n = timer - TW'(1);
      end
      default: begin
        state_n   = LOCKED;
        err_cnt_n = '0;
        timer_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOCKED;
      timer   <= '0;
      err_cnt <= '0;
      right_q <= 1'b0;
      error_q <= 1'b0;
      lock    <= 1'b1;
      unlock  <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      err_cnt <= err_cnt_n;
      right_q <= right;
      error_q <= error;
      lock    <= (state_n != UNLOCKED);
      unlock  <= (state_n == UNLOCKED);
    end
  end

`ifdef DEALPASS_BEEP_TOGGLE_EN
  localparam int BW = $clog2(2 * BEEP_DIV);

  logic [BW-1:0] phase, phase_n;

  // Phase restarts on every alarm entry so the wave always opens high.
  always_comb begin
    phase_n = '0;
    if (state == ALARM && phase != BW'(2 * BEEP_DIV - 1))
      phase_n = phase + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      beef  <= 1'b0;
    end else begin
      phase <= phase_n;
      beef  <= (state_n == ALARM) && (phase_n < BW'(BEEP_DIV));
    end
  end
`else
  logic unused_beep;
  assign unused_beep = ^BEEP_DIV;

  always_ff @(posedge clk) begin
    if (rst) beef <= 1'b0;
    else     beef <= (state_n == ALARM);
  end
`endif

endmodule

// File: tb/tb_deal_pass.sv
// tb_deal_pass: directed and random checks of deal_pass against a
// deadline-based reference model.
module tb_deal_pass;

  localparam int MAX_ERR      = 3;
  localparam int UNLOCK_HOLD  = 8;
  localparam int ALARM_CYCLES = 16;
  localparam int BEEP_DIV     = 4;
`ifdef DEALPASS_BEEP_TOGGLE_EN
  localparam int BEEF_TOTAL = 8;
`else
  localparam int BEEF_TOTAL = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic error = 1'b0;
  logic right = 1'b0;
  logic lock, unlock, beef;

  int checks = 0;
  int failures = 0;

  // model: edge index and deadlines
  int n = 0;
  int m_err = 0;
  int ul_start = -10, ul_end = -10;
  int al_start = -10, al_end = -10;
  bit pr = 0, pe = 0;
  int ul_cnt = 0, bf_cnt = 0;

  deal_pass #(
    .MAX_ERR(MAX_ERR),
    .UNLOCK_HOLD(UNLOCK_HOLD),
    .ALARM_CYCLES(ALARM_CYCLES),
    .BEEP_DIV(BEEP_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .error(error),
    .right(right),
    .lock(lock),
    .unlock(unlock),
    .beef(beef)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit rs);
    bit evr, eve, in_al, in_ul;
    int cnt;
    if (rs) begin
      m_err = 0; pr = 0; pe = 0;
      ul_start = -10; ul_end = -10;
      al_start = -10; al_end = -10;
      return;
    end
    evr = r && !pr;
    eve = e && !pe;
    pr = r;
    pe = e;
    in_al = (n > al_start) && (n <= al_end);
    in_ul = (n > ul_start) && (n <= ul_end);
    if (in_al) return;
    if (eve) begin
      cnt = in_ul ? 0 : m_err;
      if (in_ul) ul_end = n;
      if (cnt + 1 == MAX_ERR) begin
        al_start = n;
        al_end = n + ALARM_CYCLES;
        m_err = 0;
      end else begin
        m_err = cnt + 1;
      end
    end else if (evr) begin
      if (!in_ul) ul_start = n;
      ul_end = n + UNLOCK_HOLD;
      m_err = 0;
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic rs);
    bit x_ul, x_bf;
    right = r;
    error = e;
    rst = rs;
    @(posedge clk);
    n++;
    model(r, e, rs);
    #1;
    x_ul = (n >= ul_start) && (n < ul_end);
    x_bf = (n >= al_start) && (n < al_end);
`ifdef DEALPASS_BEEP_TOGGLE_EN
    x_bf = x_bf && (((n - al_start) / BEEP_DIV) % 2 == 0);
`endif
    check("lock", lock, !x_ul);
    check("unlock", unlock, x_ul);
    check("beef", beef, x_bf);
    if (unlock === 1'b1) ul_cnt++;
    if (beef === 1'b1) bf_cnt++;
  endtask

  task automatic pulse(input logic r, input logic e, input int hold,
                       input int gap);
    repeat (hold) tick(r, e, 1'b0);
    repeat (gap) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit r, e, rs;

    tick(0, 0, 1);
    tick(0, 0, 1);
    check("rst_lock", lock, 1'b1);
    check("rst_beef", beef, 1'b0);

    // right raised during reset, held 5 clocks
    tick(1, 0, 1);
    ul_cnt = 0;
    tick(1, 0, 0);
    check("unlock_first", unlock, 1'b1);
    repeat (3) tick(1, 0, 0);
    repeat (16) tick(0, 0, 0);
    check_int("hold_len", ul_cnt, UNLOCK_HOLD);

    // two errors, right clears count, then three errors alarm
    pulse(0, 1, 1, 1);
    pulse(0, 1, 1, 1);
    pulse(1, 0, 1, 0);
    check("unlock_after_err", unlock, 1'b1);
    bf_cnt = 0;
    pulse(0, 1, 1, 1);
    check("err_locks", lock, 1'b1);
    pulse(0, 1, 1, 1);
    pulse(0, 1, 1, 20);
    check_int("alarm_len_a", bf_cnt, BEEF_TOTAL);

    // three long errors, right during alarm ignored
    bf_cnt = 0;
    ul_cnt = 0;
    pulse(0, 1, 7, 1);
    pulse(0, 1, 7, 1);
    pulse(0, 1, 7, 1);
    pulse(1, 0, 2, 20);
    check_int("alarm_len_b", bf_cnt, BEEF_TOTAL);
    check_int("alarm_no_unlock", ul_cnt, 0);
    tick(1, 0, 0);
    check("unlock_post_alarm", unlock, 1'b1);
    pulse(0, 0, 0, 10);

    // simultaneous right and error is an error
    tick(1, 1, 0);
    check("simul_locked", lock, 1'b1);
    pulse(0, 0, 0, 1);
    pulse(1, 0, 1, 1);
    tick(0, 1, 0);
    check("err_while_unlocked", lock, 1'b1);
    tick(0, 0, 1);

    // random traffic with occasional reset
    repeat (800) begin
      rs = ($urandom_range(0, 99) == 0);
      r = ($urandom_range(0, 5) == 0) ? ~right : right;
      e = ($urandom_range(0, 4) == 0) ? ~error : error;
      tick(r, e, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
